// File: rtl/mux4to1_rr.sv
// mux4to1_rr: merges four valid/ready source channels onto one registered
// output stream using round-robin arbitration. Each output beat carries the
// index of its source channel, and a wrapping counter tracks delivered beats.
//
// Handshake semantics (all channels, input and output side):
//   A beat transfers on a rising clk edge where valid && ready are both high.
//   A source may not make valid depend on ready; ready may depend on valid.
//   Once valid is raised, the source holds it and its data stable until the
//   transfer happens. in_ready is computed combinationally from in_valid,
//   out_valid, out_ready and the round-robin pointer.
module mux4to1_rr #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             in_valid,
    output logic [3:0]             in_ready,
    input  logic [DATA_WIDTH-1:0]  Data_in_0,
    input  logic [DATA_WIDTH-1:0]  Data_in_1,
    input  logic [DATA_WIDTH-1:0]  Data_in_2,
    input  logic [DATA_WIDTH-1:0]  Data_in_3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  Data_out,
    output logic [1:0]             sel,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    // Output register and arbitration state
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_data_out;
    logic [1:0]             r_sel;
    logic [COUNT_WIDTH-1:0] r_xfer_count;
    logic [1:0]             r_rr_ptr;

    // Combinational arbitration results
    logic                   w_load_en;
    logic                   w_out_xfer;
    logic                   w_grant_found;
    logic [1:0]             w_grant_idx;
    logic [1:0]             w_scan_idx;
    logic [3:0]             w_in_ready;
    logic [DATA_WIDTH-1:0]  w_grant_data;

    // The output register may accept a new beat when empty or draining this
    // cycle, so a full register refills in the same cycle it empties.
    assign w_load_en  = !rst && (!r_out_valid || out_ready);
    assign w_out_xfer = r_out_valid && out_ready;

    // Round-robin scan starting at r_rr_ptr. The scan runs from the farthest
    // position back to the nearest so the last hit is the first in order.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = 2'd0;
        w_scan_idx    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_scan_idx = r_rr_ptr + 2'(k);
            if (in_valid[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
            end
        end
    end

    // One-hot ready towards the granted channel, only when a load can happen
    always_comb begin
        w_in_ready = 4'b0000;
        if (w_load_en && w_grant_found) begin
            w_in_ready = 4'b0001 << w_grant_idx;
        end
    end

    // Select the data of the granted channel
    always_comb begin
        w_grant_data = Data_in_0;
        case (w_grant_idx)
            2'd0: w_grant_data = Data_in_0;
            2'd1: w_grant_data = Data_in_1;
            2'd2: w_grant_data = Data_in_2;
            2'd3: w_grant_data = Data_in_3;
            default: w_grant_data = Data_in_0;
        endcase
    end

    // Output register, pointer advance and delivered-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_data_out   <= '0;
            r_sel        <= 2'd0;
            r_xfer_count <= '0;
            r_rr_ptr     <= 2'd0;
        end else begin
            if (w_out_xfer) begin
                r_xfer_count <= r_xfer_count + COUNT_WIDTH'(1);
            end
            if (w_load_en) begin
                if (w_grant_found) begin
                    r_out_valid <= 1'b1;
                    r_data_out  <= w_grant_data;
                    r_sel       <= w_grant_idx;
                    r_rr_ptr    <= w_grant_idx + 2'd1;
                end else begin
                    // Nothing to load: register empties, data/sel keep last beat
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign Data_out   = r_data_out;
    assign sel        = r_sel;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_mux4to1_rr.sv
// Directed bench for mux4to1_rr: a cycle table for the steady-state
// arbitration cases plus hand-written reset, backpressure and wrap sequences.
module tb_mux4to1_rr;

    localparam int DW = 8;
    localparam int CW = 4;

    // Clock / reset
    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [DW-1:0] Data_in_0, Data_in_1, Data_in_2, Data_in_3;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Data_out;
    logic [1:0]    sel;
    logic [CW-1:0] xfer_count;

    always #5 clk = ~clk;

    mux4to1_rr #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Data_in_0  (Data_in_0),
        .Data_in_1  (Data_in_1),
        .Data_in_2  (Data_in_2),
        .Data_in_3  (Data_in_3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Data_out   (Data_out),
        .sel        (sel),
        .xfer_count (xfer_count)
    );

    // One table row = one clock cycle: inputs, ready expected before the
    // edge, registered outputs expected after it.
    typedef struct {
        logic [3:0]         iv;
        logic               ordy;
        logic [3:0][DW-1:0] din;
        logic [3:0]         exp_rdy;
        logic               exp_ov;
        logic [DW-1:0]      exp_data;
        logic [1:0]         exp_sel;
        logic [CW-1:0]      exp_cnt;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0][DW-1:0] d_def;
    logic [3:0][DW-1:0] d_a5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] iv, input logic ordy, input logic [3:0][DW-1:0] din);
        in_valid  = iv;
        out_ready = ordy;
        Data_in_0 = din[0];
        Data_in_1 = din[1];
        Data_in_2 = din[2];
        Data_in_3 = din[3];
    endtask

    // Post-edge check of all registered outputs
    task automatic check_out(input string tag, input logic ov, input logic [DW-1:0] d,
                             input logic [1:0] s, input logic [CW-1:0] c);
        check({tag, ".out_valid"},  32'(out_valid),  32'(ov));
        check({tag, ".Data_out"},   32'(Data_out),   32'(d));
        check({tag, ".sel"},        32'(sel),        32'(s));
        check({tag, ".xfer_count"}, 32'(xfer_count), 32'(c));
    endtask

    function automatic vec_t mk(logic [3:0] iv, logic ordy, logic [3:0][DW-1:0] din,
                                logic [3:0] rdy, logic ov, logic [DW-1:0] d,
                                logic [1:0] s, logic [CW-1:0] c);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.din = din; v.exp_rdy = rdy;
        v.exp_ov = ov; v.exp_data = d; v.exp_sel = s; v.exp_cnt = c;
        return v;
    endfunction

    initial begin
        d_def = {8'h13, 8'h12, 8'h11, 8'h10};
        d_a5  = {8'h13, 8'hA5, 8'h11, 8'h10};

        // Round robin, all valid, out_ready=1: grants 0,1,2,3,0,1,2,3
        vecs[0]  = mk(4'b1111, 1'b1, d_def, 4'b0001, 1'b1, 8'h10, 2'd0, 4'd0);
        vecs[1]  = mk(4'b1111, 1'b1, d_def, 4'b0010, 1'b1, 8'h11, 2'd1, 4'd1);
        vecs[2]  = mk(4'b1111, 1'b1, d_def, 4'b0100, 1'b1, 8'h12, 2'd2, 4'd2);
        vecs[3]  = mk(4'b1111, 1'b1, d_def, 4'b1000, 1'b1, 8'h13, 2'd3, 4'd3);
        vecs[4]  = mk(4'b1111, 1'b1, d_def, 4'b0001, 1'b1, 8'h10, 2'd0, 4'd4);
        vecs[5]  = mk(4'b1111, 1'b1, d_def, 4'b0010, 1'b1, 8'h11, 2'd1, 4'd5);
        vecs[6]  = mk(4'b1111, 1'b1, d_def, 4'b0100, 1'b1, 8'h12, 2'd2, 4'd6);
        vecs[7]  = mk(4'b1111, 1'b1, d_def, 4'b1000, 1'b1, 8'h13, 2'd3, 4'd7);
        // Idle: last beat drains (count 8), data/sel hold, out_valid drops
        vecs[8]  = mk(4'b0000, 1'b1, d_def, 4'b0000, 1'b0, 8'h13, 2'd3, 4'd8);
        // Single channel 2 with A5 (pointer at 0)
        vecs[9]  = mk(4'b0100, 1'b1, d_a5,  4'b0100, 1'b1, 8'hA5, 2'd2, 4'd8);
        vecs[10] = mk(4'b0000, 1'b1, d_a5,  4'b0000, 1'b0, 8'hA5, 2'd2, 4'd9);
        // Pointer skip: after grant 2, channels 0 and 3 valid -> 3 then 0
        vecs[11] = mk(4'b1001, 1'b1, d_def, 4'b1000, 1'b1, 8'h13, 2'd3, 4'd9);
        vecs[12] = mk(4'b1001, 1'b1, d_def, 4'b0001, 1'b1, 8'h10, 2'd0, 4'd10);
        vecs[13] = mk(4'b0000, 1'b1, d_def, 4'b0000, 1'b0, 8'h10, 2'd0, 4'd11);
        // Pointer at 1, only channel 0 valid: scan wraps past 3 back to 0
        vecs[14] = mk(4'b0001, 1'b1, d_def, 4'b0001, 1'b1, 8'h10, 2'd0, 4'd11);

        // Reset held 2 cycles with all channels requesting
        rst = 1'b1;
        drive(4'b1111, 1'b1, d_def);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'h0);
        step();
        check("rst.in_ready_c1", 32'(in_ready), 32'h0);
        step();
        check_out("rst", 1'b0, 8'h00, 2'd0, 4'd0);
        rst = 1'b0;

        // Table-driven cycles
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].din);
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_data,
                      vecs[i].exp_sel, vecs[i].exp_cnt);
        end

        // Backpressure: beat (10, sel 0) held 5 cycles while all channels request
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0, d_def);
            #1;
            check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
            step();
            check_out($sformatf("bp%0d", i), 1'b1, 8'h10, 2'd0, 4'd11);
        end
        // Release: drain and refill in the same cycle, pointer at 1
        drive(4'b1111, 1'b1, d_def);
        #1;
        check("bp_rel.in_ready", 32'(in_ready), 32'b0010);
        step();
        check_out("bp_rel", 1'b1, 8'h11, 2'd1, 4'd12);

        // Reset mid-operation with a beat held
        rst = 1'b1;
        drive(4'b1111, 1'b1, d_def);
        #1;
        check("midrst.in_ready", 32'(in_ready), 32'h0);
        step();
        check_out("midrst", 1'b0, 8'h00, 2'd0, 4'd0);
        rst = 1'b0;

        // Wrap: 17 back-to-back grants from reset, pointer restarts at 0
        for (int j = 0; j < 17; j++) begin
            drive(4'b1111, 1'b1, d_def);
            #1;
            check($sformatf("wrap%0d.in_ready", j), 32'(in_ready), 32'(4'b0001 << (j % 4)));
            step();
            check($sformatf("wrap%0d.sel", j), 32'(sel), 32'(j % 4));
            check($sformatf("wrap%0d.xfer_count", j), 32'(xfer_count), 32'(j % 16));
        end
        // Drain the last beat: 17th transfer, counter wraps to 1
        drive(4'b0000, 1'b1, d_def);
        #1;
        check("wrap_end.in_ready", 32'(in_ready), 32'h0);
        step();
        check_out("wrap_end", 1'b0, 8'h10, 2'd0, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4to1_rr.md
Name: mux4to1_rr

Overview:
Four-input to one-output stream multiplexer with round-robin arbitration. It is the gathering counterpart of the 1-to-4 demultiplexer. Four valid/ready source channels are merged onto one registered output stream, and each output beat is tagged with the 2-bit index of the channel it came from. A wrapping counter tracks the total number of delivered beats.

Parameters:
DATA_WIDTH, 8, width of every data bus
COUNT_WIDTH, 16, width of the delivered-beat counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  4  bit i = channel i presents data
in_ready  output  4  bit i = channel i beat accepted this cycle; at most one bit high
Data_in_0  input  DATA_WIDTH  channel 0 data
Data_in_1  input  DATA_WIDTH  channel 1 data
Data_in_2  input  DATA_WIDTH  channel 2 data
Data_in_3  input  DATA_WIDTH  channel 3 data
out_valid  output  1  output register holds a beat
out_ready  input  1  downstream accepts the beat
Data_out  output  DATA_WIDTH  registered output data
sel  output  2  source channel index of the current output beat
xfer_count  output  COUNT_WIDTH  number of completed output handshakes, wrapping

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, Data_out=0, sel=0, xfer_count=0, rr_ptr=0. While rst=1, in_ready=0. Reset mid-transfer drops the held beat; no handshake counts in the reset cycle.
- Handshakes:
  - Input transfer on channel i: in_valid[i] && in_ready[i] at a clk edge.
  - Output transfer: out_valid && out_ready at a clk edge.
- Load enable: load_en = !rst && (!out_valid || out_ready). The output register can therefore refill in the same cycle it drains.
- Grant (combinational):
  - When load_en=1, scan channels in order rr_ptr, rr_ptr+1, ... (mod 4).
  - The first channel with in_valid=1 is granted. in_ready = one-hot of that channel.
  - If no channel is valid or load_en=0, in_ready=0.
  - in_ready may depend combinationally on in_valid. in_valid must not depend on in_ready.
- On an input transfer from channel g:
  - Data_out <= Data_in_g, sel <= g, out_valid <= 1.
  - rr_ptr <= g+1 mod 4 (3 wraps to 0).
- If load_en=1 and no channel is valid: out_valid <= 0; Data_out and sel hold their last values; rr_ptr holds.
- If load_en=0 (out_valid=1, out_ready=0): Data_out, sel and out_valid hold stable; rr_ptr holds.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid.
  - Sustained 1 beat/cycle while out_ready=1 and any channel is valid.
- Fairness: a continuously requesting channel waits at most 3 grants. Pending requests are never starved.
- xfer_count: increments by 1 on each output transfer. Wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Simultaneous output transfer and input transfer in one cycle: the new beat replaces the old one, out_valid stays 1, and xfer_count increments.
- Channels that are valid but not granted must keep their data stable until they are granted; the block does not check this.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, sel=0, xfer_count=0; the first grant after release goes to channel 0.
- Single channel: in_valid=0100, Data_in_2=8'hA5, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, Data_out=8'hA5, sel=2; xfer_count=1 one cycle later.
- Round robin: in_valid=1111, Data_in_k=8'h10+k, out_ready=1, 8 cycles -> sel sequence 0,1,2,3,0,1,2,3 back-to-back; xfer_count=8.
- Pointer skip: after a grant to 2, present in_valid=1001 -> channel 3 is granted first, then channel 0; sel=3 then 0.
- Backpressure: one beat held with out_ready=0 for 5 cycles while in_valid=1111 -> in_ready=0000, Data_out and sel stable. Raise out_ready -> the beat drains and the next grant loads in the same cycle.
- Reset mid-operation and wrap: with out_valid=1, assert rst for 1 cycle -> out_valid=0 and xfer_count=0 next cycle. With COUNT_WIDTH=4, 17 transfers -> xfer_count=1.
